// File: rtl/bounce_emulator.sv
// Switch-contact bounce emulator: mirrors clean_in onto noisy_out with glitch bursts.
// Optional macro BOUNCE_RANDOM_GAP_EN adds an LFSR-randomised gap between toggles.
module bounce_emulator #(
  parameter int unsigned BOUNCES   = 5,
  parameter int unsigned GAP_MIN   = 500_000,
  parameter int unsigned RAND_W    = 16,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic clk,
  input  logic reset,
  input  logic clean_in,
  input  logic bounce_en,
  output logic noisy_out,
  output logic busy,
  output logic done
);

  typedef enum logic [1:0] {
    IDLE,
    BOUNCE,
    SETTLE
  } state_t;

  localparam logic [8:0] TOG_LOAD = 9'(2 * BOUNCES);
  localparam logic       BURST_ON = (BOUNCES > 0);

  generate
    if (BOUNCES > 255 || GAP_MIN < 1 || GAP_MIN > 32'd16777215 ||
        RAND_W < 1 || RAND_W > 16 || LFSR_SEED == '0) begin : g_bad_cfg
      $error("bounce_emulator: parameter out of range");
    end
  endgenerate

  state_t      state, state_n;
  logic        noisy_n;
  logic        target, target_n;
  logic [8:0]  tog_cnt, tog_n;
  logic [24:0] gap_cnt, gap_n;
  logic [24:0] gap_load;

`ifdef BOUNCE_RANDOM_GAP_EN
  logic [15:0] lfsr;
  logic        lfsr_fb;

  // x^16 + x^14 + x^13 + x^11 + 1, free-running
  assign lfsr_fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

  always_ff @(posedge clk) begin
    if (reset) lfsr <= LFSR_SEED;
    else       lfsr <= {lfsr[14:0], lfsr_fb};
  end

  assign gap_load = 25'(GAP_MIN) + 25'(lfsr[RAND_W-1:0]);
`else
  assign gap_load = 25'(GAP_MIN);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      noisy_out <= 1'b0;
      target    <= 1'b0;
      tog_cnt   <= '0;
      gap_cnt   <= '0;
    end else begin
      state     <= state_n;
      noisy_out <= noisy_n;
      target    <= target_n;
      tog_cnt   <= tog_n;
      gap_cnt   <= gap_n;
    end
  end

  always_comb begin
    state_n  = state;
    noisy_n  = noisy_out;
    target_n = target;
    tog_n    = tog_cnt;
    gap_n    = gap_cnt;
    busy     = 1'b0;
    done     = 1'b0;
    unique case (state)
      IDLE: begin
        if (clean_in != noisy_out) begin
          noisy_n  = clean_in;
          target_n = clean_in;
          if (bounce_en && BURST_ON) begin
            tog_n   = TOG_LOAD;
            gap_n   = gap_load;
            state_n = BOUNCE;
          end
        end
      end
      BOUNCE: begin
        busy = 1'b1;
        if (tog_cnt == '0) begin
          state_n = SETTLE;
        end else if (gap_cnt == 25'd1) begin
          noisy_n = ~noisy_out;
          tog_n   = tog_cnt - 9'd1;
          gap_n   = gap_load;
        end else begin
          gap_n = gap_cnt - 25'd1;
        end
      end
      SETTLE: begin
        // even toggle count already left noisy_out at target
        done    = 1'b1;
        noisy_n = target;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_bounce_emulator.sv
// Self-checking bench for bounce_emulator (BOUNCES=2, GAP_MIN=4, RAND_W=4).
// With BOUNCE_RANDOM_GAP_EN defined it checks gap range and repeatability instead.
module tb_bounce_emulator;

  logic clk = 1'b0;
  logic reset, clean_in, bounce_en;
  logic noisy_out, busy, done;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic n;
    logic b;
    logic d;
  } exp_t;

  typedef struct {
    logic rst;
    logic ci;
    logic be;
    exp_t e;
  } vec_t;

  exp_t sb[$];

  bounce_emulator #(
    .BOUNCES  (2),
    .GAP_MIN  (4),
    .RAND_W   (4),
    .LFSR_SEED(16'hACE1)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .clean_in (clean_in),
    .bounce_en(bounce_en),
    .noisy_out(noisy_out),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  // Expected outputs k cycles after a burst-starting edge to level lvl
  function automatic exp_t burst_exp(int k, logic lvl);
    exp_t e;
    int   n;
    n = (k - 1) / 4;
    if (n > 4) n = 4;
    e.n = lvl ^ n[0];
    e.b = (k >= 1 && k <= 17);
    e.d = (k == 18);
    return e;
  endfunction

  function automatic exp_t mk(logic n, logic b, logic d);
    exp_t e;
    e.n = n;
    e.b = b;
    e.d = d;
    return e;
  endfunction

  task automatic step(input logic r, input logic c, input logic b,
                      input exp_t e, input string nm);
    exp_t w;
    sb.push_back(e);
    reset     = r;
    clean_in  = c;
    bounce_en = b;
    @(posedge clk);
    #1;
    w = sb.pop_front();
    checks++;
    if (noisy_out !== w.n || busy !== w.b || done !== w.d) begin
      errors++;
      $display("FAIL %s @%0t: got noisy=%b busy=%b done=%b, want noisy=%b busy=%b done=%b",
               nm, $time, noisy_out, busy, done, w.n, w.b, w.d);
    end
  endtask

`ifdef BOUNCE_RANDOM_GAP_EN
  int iv_cur[4];
  int iv_ref[4];

  task automatic rand_run();
    int   last;
    int   n;
    logic prev;
    reset     = 1'b1;
    clean_in  = 1'b0;
    bounce_en = 1'b1;
    @(posedge clk);
    #1;
    reset    = 1'b0;
    clean_in = 1'b1;
    prev     = noisy_out;
    last     = 0;
    n        = 0;
    for (int cyc = 1; cyc <= 400 && n < 5; cyc++) begin
      @(posedge clk);
      #1;
      if (noisy_out !== prev) begin
        if (n > 0) iv_cur[n-1] = cyc - last;
        last = cyc;
        prev = noisy_out;
        n++;
      end
    end
    checks++;
    if (n != 5) begin
      errors++;
      $display("FAIL rand_toggles: got %0d edges, want 5", n);
    end
  endtask
`endif

  initial begin
    vec_t tbl[8];

    reset     = 1'b1;
    clean_in  = 1'b0;
    bounce_en = 1'b0;

`ifdef BOUNCE_RANDOM_GAP_EN
    rand_run();
    for (int i = 0; i < 4; i++) begin
      iv_ref[i] = iv_cur[i];
      checks++;
      if (iv_cur[i] < 4 || iv_cur[i] > 19) begin
        errors++;
        $display("FAIL rand_range[%0d]: got %0d, want 4..19", i, iv_cur[i]);
      end
    end
    rand_run();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (iv_cur[i] != iv_ref[i]) begin
        errors++;
        $display("FAIL rand_repeat[%0d]: got %0d, want %0d", i, iv_cur[i], iv_ref[i]);
      end
    end
`else
    // reset, then plain mirroring with bounce disabled
    tbl[0] = '{1'b1, 1'b0, 1'b0, mk(0, 0, 0)};
    tbl[1] = '{1'b0, 1'b0, 1'b0, mk(0, 0, 0)};
    tbl[2] = '{1'b0, 1'b1, 1'b0, mk(1, 0, 0)};
    tbl[3] = '{1'b0, 1'b1, 1'b0, mk(1, 0, 0)};
    tbl[4] = '{1'b0, 1'b0, 1'b0, mk(0, 0, 0)};
    tbl[5] = '{1'b0, 1'b1, 1'b0, mk(1, 0, 0)};
    tbl[6] = '{1'b0, 1'b0, 1'b0, mk(0, 0, 0)};
    tbl[7] = '{1'b0, 1'b0, 1'b0, mk(0, 0, 0)};
    for (int i = 0; i < 8; i++)
      step(tbl[i].rst, tbl[i].ci, tbl[i].be, tbl[i].e, "table");

    // 0->1 burst with a 1->0->1 glitch on clean_in mid-burst
    for (int i = 0; i <= 19; i++)
      step(1'b0, (i == 6 || i == 7) ? 1'b0 : 1'b1, 1'b1,
           burst_exp(i + 1, 1'b1), "burst_pulse");

    // 1->0 burst, bounce_en dropped mid-burst
    for (int i = 0; i <= 18; i++)
      step(1'b0, 1'b0, (i < 6) ? 1'b1 : 1'b0,
           burst_exp(i + 1, 1'b0), "burst_en_drop");

    // clean_in falls mid-burst: second burst follows the first
    for (int i = 0; i <= 18; i++)
      step(1'b0, (i < 10) ? 1'b1 : 1'b0, 1'b1,
           burst_exp(i + 1, 1'b1), "burst_first");
    for (int i = 19; i <= 37; i++)
      step(1'b0, 1'b0, 1'b1, burst_exp(i - 18, 1'b0), "burst_second");

    // reset mid-burst aborts without done, fresh burst follows
    for (int i = 0; i <= 6; i++)
      step(1'b0, 1'b1, 1'b1, burst_exp(i + 1, 1'b1), "pre_reset");
    step(1'b1, 1'b1, 1'b1, mk(0, 0, 0), "mid_reset");
    for (int i = 8; i <= 26; i++)
      step(1'b0, 1'b1, 1'b1, burst_exp(i - 7, 1'b1), "post_reset");
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
